// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: FSM state encodings and the
// bit positions of the architectural flags written by the ALU.
package alu_issue_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int ZERO_IDX                    = 0;
    localparam int DIVISION_HAS_REMAINDER_IDX  = 1;
    localparam int DIVISION_BY_ZERO_IDX        = 2;
    localparam int MULTIPLICATION_OVERFLOW_IDX = 3;

endpackage

// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper around an external combinational ALU: registers an op,
// holds operands for a settle window, then captures the result and the flags.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int L             = 16,
    parameter int P             = 0,
    parameter int RW            = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [P:0]    InOperation,
    input  logic [L-1:0]  InA,
    input  logic [L-1:0]  InB,
    input  logic [RW-1:0] InDest,
    input  logic          Flush,
    output logic [P:0]    AluOperation,
    output logic [L-1:0]  AluA,
    output logic [L-1:0]  AluB,
    output logic [L-1:0]  AluFlagsIn,
    input  logic [L-1:0]  AluR,
    input  logic [L-1:0]  AluFlagsOut,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [L-1:0]  OutData,
    output logic [RW-1:0] OutDest,
    output logic [L-1:0]  Flags
);

    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [P:0]    op_q;
    logic [L-1:0]  a_q;
    logic [L-1:0]  b_q;
    logic [RW-1:0] dest_q;
    logic [L-1:0]  out_data_q;
    logic [RW-1:0] out_dest_q;
    logic [L-1:0]  flags_q;
    logic [L-1:0]  flags_d;

    logic in_ready_s;
    logic out_valid_s;
    logic accept_s;
    logic capture_s;

    // Handshake qualifiers; a flush suppresses both accept and capture.
    always_comb begin
        accept_s  = InValid & in_ready_s & ~Flush;
        capture_s = (state_q == ST_SETTLE) & (cnt_q == {CW{1'b0}}) & ~Flush;
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) state_d = ST_SETTLE;
                    else          state_d = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == {CW{1'b0}}) state_d = ST_HOLD;
                    else                     state_d = ST_SETTLE;
                end
                ST_HOLD: begin
                    if (accept_s)      state_d = ST_SETTLE;
                    else if (OutReady) state_d = ST_IDLE;
                    else               state_d = ST_HOLD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; HOLD accepts only when the held result is being consumed.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_SETTLE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            ST_HOLD: begin
                in_ready_s  = OutReady;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Captured flags take the ALU word but recompute Zero from the result.
    always_comb begin
        flags_d           = AluFlagsOut;
        flags_d[ZERO_IDX] = (AluR == {L{1'b0}});
    end

    // Settle counter, operand latch and result/flags capture.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= {CW{1'b0}};
            op_q       <= {(P+1){1'b0}};
            a_q        <= {L{1'b0}};
            b_q        <= {L{1'b0}};
            dest_q     <= {RW{1'b0}};
            out_data_q <= {L{1'b0}};
            out_dest_q <= {RW{1'b0}};
            flags_q    <= {L{1'b0}};
        end else begin
            if (Flush) begin
                cnt_q <= {CW{1'b0}};
            end else if (accept_s) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == ST_SETTLE) && (cnt_q != {CW{1'b0}})) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (accept_s) begin
                op_q   <= InOperation;
                a_q    <= InA;
                b_q    <= InB;
                dest_q <= InDest;
            end
            if (capture_s) begin
                out_data_q <= AluR;
                out_dest_q <= dest_q;
                flags_q    <= flags_d;
            end
        end
    end

    assign InReady      = in_ready_s;
    assign OutValid     = out_valid_s;
    assign AluOperation = op_q;
    assign AluA         = a_q;
    assign AluB         = b_q;
    assign AluFlagsIn   = flags_q;
    assign OutData      = out_data_q;
    assign OutDest      = out_dest_q;
    assign Flags        = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a stand-in ALU and a transaction-level
// model of the stage that is compared against the DUT on every falling edge.
module tb_alu_issue_stage;

    localparam int L      = 16;
    localparam int RW     = 3;
    localparam int SETTLE = 2;
    localparam int Z_I = 0, REM_I = 1, DZ_I = 2, OVF_I = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [0:0]    InOperation = 1'b0;
    logic [L-1:0]  InA = '0, InB = '0;
    logic [RW-1:0] InDest = '0;
    logic          Flush = 1'b0;
    logic [0:0]    AluOperation;
    logic [L-1:0]  AluA, AluB, AluFlagsIn, AluR, AluFlagsOut;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [L-1:0]  OutData;
    logic [RW-1:0] OutDest;
    logic [L-1:0]  Flags;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_stage #(.L(L), .P(0), .RW(RW), .SETTLE_CYCLES(SETTLE)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InOperation(InOperation), .InA(InA), .InB(InB), .InDest(InDest),
        .Flush(Flush), .AluOperation(AluOperation), .AluA(AluA), .AluB(AluB),
        .AluFlagsIn(AluFlagsIn), .AluR(AluR), .AluFlagsOut(AluFlagsOut),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutDest(OutDest), .Flags(Flags)
    );

    always #5 Clock = ~Clock;

    // Reference ALU: returns {flags, result}; untouched flag bits pass through.
    function automatic logic [2*L-1:0] alu_ref(input logic op, input logic [L-1:0] a,
                                               input logic [L-1:0] b, input logic [L-1:0] fin);
        logic signed [2*L-1:0] p;
        logic [L-1:0] r;
        logic [L-1:0] f;
        f = fin;
        r = '0;
        if (op == 1'b0) begin
            if (b == '0) begin
                r = '0;
                f[DZ_I] = 1'b1;
                f[REM_I] = 1'b0;
            end else begin
                r = $signed(a) / $signed(b);
                f[DZ_I] = 1'b0;
                f[REM_I] = (($signed(a) % $signed(b)) != 0);
            end
        end else begin
            p = $signed(a) * $signed(b);
            r = p[L-1:0];
            f[OVF_I] = (p != {{L{r[L-1]}}, r});
        end
        return {f, r};
    endfunction

    always_comb {AluFlagsOut, AluR} = alu_ref(AluOperation[0], AluA, AluB, AluFlagsIn);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending op with an edge countdown, one held result.
    logic          m_pend = 1'b0;
    int            m_left = 0;
    logic          m_op;
    logic [L-1:0]  m_a, m_b;
    logic [RW-1:0] m_pdest;
    logic          m_valid = 1'b0;
    logic [L-1:0]  m_data = '0;
    logic [RW-1:0] m_dest = '0;
    logic [L-1:0]  m_flags = '0;

    function automatic logic model_ready();
        return !m_pend && (!m_valid || OutReady);
    endfunction

    always @(posedge Clock or posedge Reset) begin
        logic rdy;
        logic [L-1:0] r, f;
        if (Reset) begin
            m_pend = 1'b0; m_left = 0; m_valid = 1'b0;
            m_data = '0; m_dest = '0; m_flags = '0;
        end else if (Flush) begin
            m_pend = 1'b0;
            m_valid = 1'b0;
        end else begin
            rdy = model_ready();
            if (m_pend) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    {f, r} = alu_ref(m_op, m_a, m_b, m_flags);
                    f[Z_I] = (r == '0);
                    m_flags = f; m_data = r; m_dest = m_pdest;
                    m_valid = 1'b1; m_pend = 1'b0;
                end
            end else if (InValid && rdy) begin
                m_pend = 1'b1; m_left = SETTLE;
                m_op = InOperation[0]; m_a = InA; m_b = InB; m_pdest = InDest;
                m_valid = 1'b0;
            end else if (m_valid && OutReady) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clock) begin
        chk("out_valid", {31'd0, OutValid}, {31'd0, m_valid});
        chk("in_ready", {31'd0, InReady}, {31'd0, model_ready()});
        chk("flags", {16'd0, Flags}, {16'd0, m_flags});
        chk("alu_flags_in", {16'd0, AluFlagsIn}, {16'd0, m_flags});
        if (m_valid) begin
            chk("out_data", {16'd0, OutData}, {16'd0, m_data});
            chk("out_dest", {29'd0, OutDest}, {29'd0, m_dest});
        end
        if (m_pend) begin
            chk("alu_a", {16'd0, AluA}, {16'd0, m_a});
            chk("alu_b", {16'd0, AluB}, {16'd0, m_b});
        end
    end

    task automatic issue(input logic op, input logic [L-1:0] a, input logic [L-1:0] b,
                         input logic [RW-1:0] d);
        int n;
        InValid = 1'b1; InOperation = op; InA = a; InB = b; InDest = d;
        n = 0;
        while (!InReady && n < 20) begin
            @(posedge Clock); #2; n++;
        end
        if (!InReady) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge Clock); #2;
        InValid = 1'b0;
    endtask

    task automatic wait_result(input logic [L-1:0] ed, input logic [L-1:0] ef,
                               input logic [RW-1:0] edst);
        int edges;
        edges = 0;
        while (!OutValid && edges < 20) begin
            @(posedge Clock); #2; edges++;
        end
        chk("latency", edges, SETTLE);
        chk("lit_data", {16'd0, OutData}, {16'd0, ed});
        chk("lit_flags", {16'd0, Flags}, {16'd0, ef});
        chk("lit_dest", {29'd0, OutDest}, {29'd0, edst});
    endtask

    task automatic consume();
        OutReady = 1'b1;
        @(posedge Clock); #2;
        OutReady = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #2;
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_ready", {31'd0, InReady}, 32'd1);
        Reset = 1'b0;

        // Divide 12/4, then signed multiply and an overflowing multiply.
        issue(1'b0, 16'd12, 16'd4, 3'd1);
        wait_result(16'd3, 16'h0000, 3'd1);
        consume();
        issue(1'b1, 16'hFFF9, 16'd3, 3'd2);
        wait_result(16'hFFEB, 16'h0000, 3'd2);
        consume();
        issue(1'b1, 16'd300, 16'd300, 3'd3);
        wait_result(16'h5F90, 16'h0008, 3'd3);
        consume();

        // Divide by zero, then a zero product keeps the sticky divzero bit.
        issue(1'b0, 16'd7, 16'd0, 3'd4);
        wait_result(16'd0, 16'h000D, 3'd4);
        consume();
        issue(1'b1, 16'd0, 16'd5, 3'd5);
        wait_result(16'd0, 16'h0005, 3'd5);
        consume();

        // Writeback stall in HOLD, then same-edge handoff.
        issue(1'b0, 16'd100, 16'd7, 3'd5);
        wait_result(16'd14, 16'h0002, 3'd5);
        InValid = 1'b1; InOperation = 1'b1; InA = 16'd3; InB = 16'd4; InDest = 3'd6;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #2;
            chk("stall_ready", {31'd0, InReady}, 32'd0);
            chk("stall_data", {16'd0, OutData}, 32'd14);
        end
        OutReady = 1'b1;
        @(posedge Clock); #2;
        InValid = 1'b0; OutReady = 1'b0;
        wait_result(16'd12, 16'h0002, 3'd6);
        consume();

        // Asynchronous reset between edges while settling.
        issue(1'b0, 16'd50, 16'd5, 3'd2);
        #1 Reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, OutValid}, 32'd0);
        chk("arst_ready", {31'd0, InReady}, 32'd1);
        chk("arst_flags", {16'd0, Flags}, 32'd0);
        @(posedge Clock); #2;
        Reset = 1'b0;

        // Flush on the capture edge drops the result and keeps the flags.
        issue(1'b1, 16'd300, 16'd300, 3'd1);
        wait_result(16'h5F90, 16'h0008, 3'd1);
        consume();
        issue(1'b0, 16'd9, 16'd3, 3'd3);
        @(posedge Clock); #2;
        Flush = 1'b1;
        @(posedge Clock); #2;
        Flush = 1'b0;
        repeat (3) @(posedge Clock);
        #2;
        chk("flush_valid", {31'd0, OutValid}, 32'd0);
        chk("flush_flags", {16'd0, Flags}, 32'h0008);
        chk("flush_data", {16'd0, OutData}, 32'h5F90);

        repeat (2) @(posedge Clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
